vector_alu: RTL and testbench

Lane-parallel arithmetic unit for the vector processor, sitting directly downstream of the register file. It consumes the two 512-bit operand vectors the register file drives for add/multiply operations (R1, R2) and produces the two 512-bit result vectors written back into R3 and R4. Each 512-bit vector is treated as 16 unsigned 32-bit lanes. Lanes are processed iteratively, a fixed group per clock, behind a start/busy/done handshake.

---
 rtl/vp_pkg.sv | 20 ++
 rtl/vector_alu_if.sv | 25 ++
 rtl/vector_lane.sv | 34 +++
 rtl/vector_alu.sv | 122 ++++++++++++
 tb/tb_vector_alu.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/vp_pkg.sv
// Shared vector-processor definitions: vector geometry, opcode encodings and ALU states.
// The register file uses the same opcode constants.
package vp_pkg;

  localparam int VEC_W  = 512;
  localparam int LANE_W = 32;
  localparam int LANES  = VEC_W / LANE_W;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_READ = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_MUL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/vector_alu_if.sv
// Operand/result bus between the register file and the vector ALU, with start/busy/done handshake.
interface vector_alu_if
  import vp_pkg::*;
#(
  parameter int W = vp_pkg::VEC_W
);
  logic         start;
  logic [1:0]   opcode;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         busy;
  logic         done;
  logic [W-1:0] result_lo;
  logic [W-1:0] result_hi;

  modport master (
    output start, opcode, op_a, op_b,
    input  busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, opcode, op_a, op_b,
    output busy, done, result_lo, result_hi
  );
endinterface

// File: rtl/vector_lane.sv
// One combinational unsigned lane: ADD gives {carry, sum}, MUL gives the full 64-bit product.
module vector_lane
  import vp_pkg::*;
#(
  parameter int LANE_W = vp_pkg::LANE_W
) (
  input  logic [1:0]        opcode_i,
  input  logic [LANE_W-1:0] a_i,
  input  logic [LANE_W-1:0] b_i,
  output logic [LANE_W-1:0] lo_o,
  output logic [LANE_W-1:0] hi_o
);
  logic [LANE_W:0]     sum;
  logic [2*LANE_W-1:0] prod;

  assign sum  = {1'b0, a_i} + {1'b0, b_i};
  assign prod = (2*LANE_W)'(a_i) * (2*LANE_W)'(b_i);

  always_comb begin
    lo_o = '0;
    hi_o = '0;
    case (opcode_i)
      OP_ADD: begin
        lo_o = sum[LANE_W-1:0];
        hi_o = {{(LANE_W-1){1'b0}}, sum[LANE_W]};
      end
      OP_MUL: begin
        lo_o = prod[LANE_W-1:0];
        hi_o = prod[2*LANE_W-1:LANE_W];
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/vector_alu.sv
// Lane-parallel vector ALU: latches operands on start, computes LANES_PER_CYCLE lanes per RUN
// cycle into registered result vectors, then pulses done for one cycle.
module vector_alu
  import vp_pkg::*;
#(
  parameter int LANES           = vp_pkg::LANES,
  parameter int LANE_W          = vp_pkg::LANE_W,
  parameter int LANES_PER_CYCLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  vector_alu_if.slave bus
);
  localparam int VW     = LANES * LANE_W;
  localparam int GROUPS = LANES / LANES_PER_CYCLE;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LIW    = (LANES > 1) ? $clog2(LANES) : 1;

  if ((LANES % LANES_PER_CYCLE) != 0) begin : g_bad_cfg
    $error("vector_alu: LANES must be divisible by LANES_PER_CYCLE");
  end

  alu_state_t    state_q, state_d;
  logic [GW-1:0] group_q, group_d;
  logic [1:0]    op_q, op_d;
  logic [VW-1:0] a_q, a_d, b_q, b_d;
  logic [VW-1:0] lo_q, lo_d, hi_q, hi_d;
  logic          busy_q, busy_d, done_q, done_d;
  logic          accept;

  logic [LANE_W-1:0] a_lane  [LANES];
  logic [LANE_W-1:0] b_lane  [LANES];
  logic [LANE_W-1:0] lane_lo [LANES_PER_CYCLE];
  logic [LANE_W-1:0] lane_hi [LANES_PER_CYCLE];

  // Only ALU opcodes (bit 1 set) start an operation; loads/reads are for the register file.
  assign accept = (state_q == IDLE) && bus.start && bus.opcode[1];

  assign a_d  = accept ? bus.op_a   : a_q;
  assign b_d  = accept ? bus.op_b   : b_q;
  assign op_d = accept ? bus.opcode : op_q;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_split
    assign a_lane[gi] = a_q[gi*LANE_W +: LANE_W];
    assign b_lane[gi] = b_q[gi*LANE_W +: LANE_W];
  end

  for (genvar gi = 0; gi < LANES_PER_CYCLE; gi++) begin : g_lane
    logic [LIW-1:0] idx;
    assign idx = LIW'(int'(group_q) * LANES_PER_CYCLE + gi);

    vector_lane #(.LANE_W(LANE_W)) u_lane (
      .opcode_i (op_q),
      .a_i      (a_lane[idx]),
      .b_i      (b_lane[idx]),
      .lo_o     (lane_lo[gi]),
      .hi_o     (lane_hi[gi])
    );
  end

  // Each result lane is rewritten only in the RUN cycle of its own group, otherwise it holds.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_wb
    logic wr;
    assign wr = (state_q == RUN) && (group_q == GW'(gi / LANES_PER_CYCLE));
    assign lo_d[gi*LANE_W +: LANE_W] = wr ? lane_lo[gi % LANES_PER_CYCLE] : lo_q[gi*LANE_W +: LANE_W];
    assign hi_d[gi*LANE_W +: LANE_W] = wr ? lane_hi[gi % LANES_PER_CYCLE] : hi_q[gi*LANE_W +: LANE_W];
  end

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          group_d = '0;
        end
      end
      RUN: begin
        if (group_q == GW'(GROUPS - 1)) begin
          state_d = DONE;
          group_d = '0;
        end else begin
          group_d = group_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      group_q <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
endmodule

// File: tb/tb_vector_alu.sv
// Directed bench for vector_alu: expected result vectors are queued at start and checked at done.
module tb_vector_alu;
  import vp_pkg::*;

  typedef logic [511:0] vec_t;
  typedef struct packed {
    vec_t lo;
    vec_t hi;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb_q[$];
  res_t last_r = '0;

  vector_alu_if bus ();

  vector_alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic res_t model(input logic [1:0] op, input vec_t a, input vec_t b);
    res_t        r;
    logic [32:0] s;
    logic [63:0] p;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      s = {1'b0, a[i*32 +: 32]} + {1'b0, b[i*32 +: 32]};
      p = {32'h0, a[i*32 +: 32]} * {32'h0, b[i*32 +: 32]};
      if (op == OP_ADD) begin
        r.lo[i*32 +: 32] = s[31:0];
        r.hi[i*32 +: 32] = {31'h0, s[32]};
      end else begin
        r.lo[i*32 +: 32] = p[31:0];
        r.hi[i*32 +: 32] = p[63:32];
      end
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic vec_t fill(input logic [31:0] w);
    vec_t v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = w;
    return v;
  endfunction

  // Called at posedge+1; returns at posedge+1 one cycle after done.
  task automatic run_op(input string tag, input logic [1:0] op, input vec_t a, input vec_t b,
                        input bit scramble, input bit inject);
    res_t exp_r;
    int   edges;
    int   busy_n;
    bit   got;
    sb_q.push_back(model(op, a, b));
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.op_a   = a;
    bus.op_b   = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    edges  = 0;
    busy_n = 0;
    got    = 1'b0;
    while (!got && edges < 20) begin
      if (bus.busy) busy_n++;
      if (scramble) begin
        bus.op_a   = rand_vec();
        bus.op_b   = rand_vec();
        bus.opcode = 2'($urandom);
      end
      if (inject && edges == 1) begin
        bus.start  = 1'b1;
        bus.opcode = OP_MUL;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (bus.done) got = 1'b1;
    end
    bus.start = 1'b0;
    exp_r = sb_q.pop_front();
    check({tag, "_done_seen"}, vec_t'(got), vec_t'(1));
    check({tag, "_latency"}, vec_t'(edges), vec_t'(4));
    check({tag, "_busy_cycles"}, vec_t'(busy_n), vec_t'(4));
    check({tag, "_busy_at_done"}, vec_t'(bus.busy), vec_t'(0));
    check({tag, "_lo"}, bus.result_lo, exp_r.lo);
    check({tag, "_hi"}, bus.result_hi, exp_r.hi);
    last_r = exp_r;
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, vec_t'(bus.done), vec_t'(0));
    if (inject) begin
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        check({tag, "_no_extra_done"}, vec_t'(bus.done | bus.busy), vec_t'(0));
      end
      check({tag, "_lo_kept"}, bus.result_lo, exp_r.lo);
    end
    $display("op %s opcode=%0b done_after=%0d edges lo=%0h", tag, op, edges, bus.result_lo);
  endtask

  task automatic ignored_req(input string tag, input logic [1:0] op);
    bus.start  = 1'b1;
    bus.opcode = op;
    bus.op_a   = rand_vec();
    bus.op_b   = rand_vec();
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check({tag, "_busy"}, vec_t'(bus.busy), vec_t'(0));
      check({tag, "_done"}, vec_t'(bus.done), vec_t'(0));
      @(posedge clk); #1;
    end
    check({tag, "_lo_kept"}, bus.result_lo, last_r.lo);
    check({tag, "_hi_kept"}, bus.result_hi, last_r.hi);
    $display("ignored %s opcode=%0b", tag, op);
  endtask

  initial begin
    vec_t a, b;
    res_t r;
    bus.start  = 1'b0;
    bus.opcode = 2'b00;
    bus.op_a   = '0;
    bus.op_b   = '0;

    #3;
    check("por_busy", vec_t'(bus.busy), vec_t'(0));
    check("por_done", vec_t'(bus.done), vec_t'(0));
    check("por_lo", bus.result_lo, '0);
    check("por_hi", bus.result_hi, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // ADD with carry out of every lane
    run_op("add_carry", OP_ADD, fill(32'hFFFF_FFFF), fill(32'h0000_0001), 1'b0, 1'b0);
    check("add_carry_lo_const", bus.result_lo, '0);
    check("add_carry_hi_const", bus.result_hi, fill(32'h0000_0001));

    // MUL: lane 0 max*max, lanes i: i*(i+1)
    a = '0;
    b = '0;
    a[31:0] = 32'hFFFF_FFFF;
    b[31:0] = 32'hFFFF_FFFF;
    for (int i = 1; i < 16; i++) begin
      a[i*32 +: 32] = i;
      b[i*32 +: 32] = i + 1;
    end
    run_op("mul", OP_MUL, a, b, 1'b0, 1'b0);
    check("mul_lane0_lo", vec_t'(bus.result_lo[31:0]), vec_t'(32'h0000_0001));
    check("mul_lane0_hi", vec_t'(bus.result_hi[31:0]), vec_t'(32'hFFFF_FFFE));
    check("mul_lane15_lo", vec_t'(bus.result_lo[15*32 +: 32]), vec_t'(240));
    check("mul_hi_upper", vec_t'(bus.result_hi[511:32]), '0);

    ignored_req("ign_load", OP_LOAD);
    ignored_req("ign_read", OP_READ);

    run_op("add_inject", OP_ADD, rand_vec(), rand_vec(), 1'b0, 1'b1);
    run_op("mul_scramble", OP_MUL, rand_vec(), rand_vec(), 1'b1, 1'b0);
    run_op("add_scramble", OP_ADD, rand_vec(), rand_vec(), 1'b1, 1'b0);

    // Asynchronous reset from IDLE with results held
    #2 rst = 1'b0;
    #1;
    check("rst_idle_busy", vec_t'(bus.busy), vec_t'(0));
    check("rst_idle_lo", bus.result_lo, '0);
    check("rst_idle_hi", bus.result_hi, '0);
    @(posedge clk); #1 rst = 1'b1;
    last_r = '0;
    $display("reset in IDLE");

    // Reset in the middle of RUN
    run_op("mul_pre", OP_MUL, rand_vec(), rand_vec(), 1'b0, 1'b0);
    bus.start  = 1'b1;
    bus.opcode = OP_ADD;
    bus.op_a   = rand_vec();
    bus.op_b   = rand_vec();
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rst_run_busy", vec_t'(bus.busy), vec_t'(0));
    check("rst_run_done", vec_t'(bus.done), vec_t'(0));
    check("rst_run_lo", bus.result_lo, '0);
    check("rst_run_hi", bus.result_hi, '0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rst_run_no_done", vec_t'(bus.done), vec_t'(0));
    end
    rst = 1'b1;
    last_r = '0;
    $display("reset in RUN");
    @(posedge clk); #1;
    check("post_rst_idle_done", vec_t'(bus.done | bus.busy), vec_t'(0));

    run_op("add_1p2", OP_ADD, fill(32'd1), fill(32'd2), 1'b0, 1'b0);
    check("add_1p2_lo_const", bus.result_lo, fill(32'd3));
    check("add_1p2_hi_const", bus.result_hi, '0);

    r = model(OP_MUL, fill(32'h0001_0000), fill(32'h0001_0000));
    run_op("mul_2p32", OP_MUL, fill(32'h0001_0000), fill(32'h0001_0000), 1'b0, 1'b0);
    check("mul_2p32_hi_const", r.hi, fill(32'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog compared=%0d mismatched=%0d", n_cmp, n_err);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end
endmodule
